// File: rtl/port_io_scanner_pkg.sv
// Shared encodings and helpers for the remote I/O port scanner.
package port_io_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_SYNC  = 3'd1;
    localparam state_t S_ADDR  = 3'd2;
    localparam state_t S_DIR   = 3'd3;
    localparam state_t S_TURN  = 3'd4;
    localparam state_t S_READ  = 3'd5;
    localparam state_t S_WRITE = 3'd6;
    localparam state_t S_DONE  = 3'd7;

    localparam int CYCLES_PER_PORT = 5;
    localparam int FRAME_OVERHEAD  = 2;

    // Port-index width; a single port still needs a 1-bit index.
    function automatic int clog2(input int n);
        int r;
        for (r = 0; (1 << r) < n; r++) begin
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/port_io_scanner.sv
// Serial-bus master scanning NPORT remote W-bit I/O ports; inputs are
// staged per port and published together at frame end.
module port_io_scanner
    import port_io_pkg::*;
#(
    parameter int NPORT = 10,
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [NPORT*W-1:0] dir_i,
    input  logic [NPORT*W-1:0] out_i,
    output logic [NPORT*W-1:0] in_o,
    output logic               busy,
    output logic               frame_done,
    output logic [CNT_W-1:0]   frame_cnt,
    output logic               port_clk,
    output logic               port_rst,
    output logic [W-1:0]       bus_d_o,
    input  logic [W-1:0]       bus_d_i,
    output logic               bus_d_oe
);

    localparam int PW = clog2(NPORT);

    state_t                    state, state_nxt;
    logic [PW-1:0]             p;
    logic [NPORT-1:0][W-1:0]   dir_sh, out_sh, stage, in_q;
    logic                      last_port;

    assign port_clk  = clk;
    assign in_o      = in_q;
    assign last_port = (p == PW'(NPORT - 1));

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (enable) state_nxt = S_SYNC;
            S_SYNC:  state_nxt = S_ADDR;
            S_ADDR:  state_nxt = S_DIR;
            S_DIR:   state_nxt = S_TURN;
            S_TURN:  state_nxt = S_READ;
            S_READ:  state_nxt = S_WRITE;
            S_WRITE: state_nxt = last_port ? S_DONE : S_ADDR;
            S_DONE:  state_nxt = enable ? S_SYNC : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs depend only on registered state so bus_d_i never reaches a pin.
    always_comb begin
        busy       = (state != S_IDLE);
        frame_done = 1'b0;
        port_rst   = 1'b0;
        bus_d_oe   = 1'b0;
        bus_d_o    = '0;
        case (state)
            S_SYNC:  port_rst = 1'b1;
            S_ADDR:  begin bus_d_oe = 1'b1; bus_d_o = W'(p);     end
            S_DIR:   begin bus_d_oe = 1'b1; bus_d_o = dir_sh[p]; end
            S_WRITE: begin bus_d_oe = 1'b1; bus_d_o = out_sh[p]; end
            S_DONE:  frame_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            p         <= '0;
            dir_sh    <= '0;
            out_sh    <= '0;
            stage     <= '0;
            in_q      <= '0;
            frame_cnt <= '0;
        end else begin
            case (state)
                S_SYNC: begin
                    p      <= '0;
                    dir_sh <= dir_i;
                    out_sh <= out_i;
                end
                S_READ:  stage[p] <= bus_d_i;
                S_WRITE: if (!last_port) p <= p + PW'(1);
                S_DONE: begin
                    in_q      <= stage;
                    frame_cnt <= frame_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_port_io_scanner.sv
// Directed/randomized bench: a frame-position model predicts every bus cycle.
module tb_port_io_scanner;
    import port_io_pkg::*;

    localparam int NP   = 10;
    localparam int W    = 8;
    localparam int CW   = 16;
    localparam int FLEN = FRAME_OVERHEAD + CYCLES_PER_PORT * NP;
    localparam int SLEN = FRAME_OVERHEAD + CYCLES_PER_PORT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, enable;
    logic [NP*W-1:0]   dir_i, out_i, in_o;
    logic              busy, frame_done, port_clk, port_rst, bus_d_oe;
    logic [CW-1:0]     frame_cnt;
    logic [W-1:0]      bus_d_o, bus_d_i;

    logic              en_s, busy_s, done_s, pclk_s, prst_s, oe_s;
    logic [W-1:0]      dir_s, out_s, in_s, bdo_s, bdi_s;
    logic [3:0]        cnt_s;

    port_io_scanner #(.NPORT(NP), .W(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .dir_i(dir_i), .out_i(out_i),
        .in_o(in_o), .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt),
        .port_clk(port_clk), .port_rst(port_rst), .bus_d_o(bus_d_o),
        .bus_d_i(bus_d_i), .bus_d_oe(bus_d_oe)
    );

    port_io_scanner #(.NPORT(1), .W(W), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .enable(en_s), .dir_i(dir_s), .out_i(out_s),
        .in_o(in_s), .busy(busy_s), .frame_done(done_s), .frame_cnt(cnt_s),
        .port_clk(pclk_s), .port_rst(prst_s), .bus_d_o(bdo_s),
        .bus_d_i(bdi_s), .bus_d_oe(oe_s)
    );

    int tests = 0;
    int fails = 0;

    logic [NP*W-1:0] in_exp;
    logic [CW-1:0]   cnt_exp;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " busy"}, busy, 1'b0);
        chk({tag, " oe"}, bus_d_oe, 1'b0);
        chk({tag, " port_rst"}, port_rst, 1'b0);
        chk({tag, " done"}, frame_done, 1'b0);
        chk({tag, " in_o"}, in_o, in_exp);
        chk({tag, " cnt"}, frame_cnt, cnt_exp);
    endtask

    // First tick lands in SYNC. Optional host write at position mut_k,
    // optional reset at position rst_k (frame then abandoned).
    task automatic frame(input bit en_next, input int mut_k, input int mut_p,
                         input logic [W-1:0] mut_v, input int rst_k, input bit fixed_rd);
        logic [NP*W-1:0] shd, sho, newin;
        int pp, j;
        logic oe_e;
        logic [W-1:0] d_e;
        shd = '0;
        sho = '0;
        for (int q = 0; q < NP; q++)
            newin[q*W +: W] = fixed_rd ? W'(8'h30 + q) : W'($urandom);
        for (int k = 0; k < FLEN; k++) begin
            tick();
            pp = (k > 0) ? (k - 1) / CYCLES_PER_PORT : 0;
            j  = (k > 0) ? (k - 1) % CYCLES_PER_PORT : -1;
            oe_e = 1'b0;
            d_e  = '0;
            if (k > 0 && k < FLEN - 1) begin
                case (j)
                    0: begin oe_e = 1'b1; d_e = W'(pp);           end
                    1: begin oe_e = 1'b1; d_e = shd[pp*W +: W];   end
                    4: begin oe_e = 1'b1; d_e = sho[pp*W +: W];   end
                    default: ;
                endcase
            end
            chk("frame busy", busy, 1'b1);
            chk("frame port_rst", port_rst, k == 0);
            chk("frame done", frame_done, k == FLEN - 1);
            chk("frame oe", bus_d_oe, oe_e);
            if (oe_e) chk("frame bus_d_o", bus_d_o, d_e);
            chk("frame in_o stable", in_o, in_exp);
            chk("frame cnt", frame_cnt, cnt_exp);
            if (k == rst_k) begin
                rst = 1'b0;
                in_exp  = '0;
                cnt_exp = '0;
                return;
            end
            if (k == mut_k) out_i[mut_p*W +: W] = mut_v;
            if (k == 0) begin
                enable = en_next;
                shd = dir_i;
                sho = out_i;
            end
            bus_d_i = (j == 3) ? newin[pp*W +: W] : W'($urandom);
            if (k == FLEN - 1) begin
                in_exp  = newin;
                cnt_exp = cnt_exp + 1'b1;
            end
        end
    endtask

    task automatic rand_host();
        for (int q = 0; q < NP; q++) begin
            dir_i[q*W +: W] = W'($urandom);
            out_i[q*W +: W] = W'($urandom);
        end
    endtask

    initial begin
        logic [3:0]   cs;
        logic [W-1:0] rd_s, in_s_exp;
        rst = 1'b0; enable = 1'b0; dir_i = '0; out_i = '0; bus_d_i = '0;
        en_s = 1'b0; dir_s = 8'h3C; out_s = 8'h5A; bdi_s = '0;
        in_exp = '0; cnt_exp = '0;

        // Reset, then remain idle with enable low
        repeat (3) tick();
        chk_idle("reset");
        rst = 1'b1;
        repeat (8) tick();
        chk_idle("idle");

        // Single frame with fixed read-back values 30+p
        rand_host();
        dir_i[3*W +: W] = 8'hF0;
        out_i[3*W +: W] = 8'hA5;
        enable = 1'b1;
        frame(1'b0, -1, 0, '0, -1, 1'b1);
        tick();
        chk_idle("after single");
        for (int q = 0; q < NP; q++)
            chk("in_o 30+p", in_o[q*W +: W], W'(8'h30 + q));

        // Snapshot: host writes port 9 while port 2 is active
        rand_host();
        out_i[9*W +: W] = 8'h11;
        enable = 1'b1;
        frame(1'b1, 1 + CYCLES_PER_PORT * 2, 9, 8'h22, -1, 1'b0);
        frame(1'b0, -1, 0, '0, -1, 1'b0);
        tick();
        chk_idle("after snapshot");

        // Reset during READ of port 5, then a clean restart
        enable = 1'b1;
        frame(1'b1, -1, 0, '0, 1 + CYCLES_PER_PORT * 5 + 3, 1'b0);
        tick();
        chk_idle("mid-frame reset");
        rst = 1'b1;
        enable = 1'b1;
        rand_host();
        frame(1'b0, -1, 0, '0, -1, 1'b0);
        tick();
        chk_idle("after restart");

        // Random back-to-back frames, enable dropped inside the last one
        enable = 1'b1;
        for (int f = 0; f < 3; f++) begin
            rand_host();
            frame(f < 2, -1, 0, '0, -1, 1'b0);
        end
        tick();
        chk_idle("after random run");

        // Single-port, 4-bit counter: continuous frames and wrap
        cs = '0;
        in_s_exp = '0;
        en_s = 1'b1;
        for (int f = 0; f < 18; f++) begin
            rd_s = W'($urandom);
            for (int k = 0; k < SLEN; k++) begin
                tick();
                chk("small done", done_s, k == SLEN - 1);
                chk("small oe", oe_s, (k == 1) || (k == 2) || (k == 5));
                chk("small cnt", cnt_s, cs);
                chk("small in_o", in_s, in_s_exp);
                if (k == 1) chk("small addr", bdo_s, 8'h00);
                if (k == 5) chk("small write", bdo_s, out_s);
                if (k == 0 && f == 17) en_s = 1'b0;
                bdi_s = (k == 4) ? rd_s : W'($urandom);
                if (k == SLEN - 1) begin
                    cs = cs + 1'b1;
                    in_s_exp = rd_s;
                end
            end
        end
        tick();
        chk("small idle busy", busy_s, 1'b0);
        chk("small final cnt", cnt_s, 4'd2);
        chk("small final in_o", in_s, in_s_exp);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
